// File: rtl/seq_shift_add_mult.sv
// Sequential shift-and-add multiplier: one multiplier bit per clock, WIDTH cycles per product.
// Optional signed mode (sgn port, magnitude multiply plus final negate) is enabled by SEQ_MULT_SIGNED_EN.
module seq_shift_add_mult #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
`ifdef SEQ_MULT_SIGNED_EN
    input  logic                 sgn,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [WIDTH-1:0]       r_mcand;
    logic [WIDTH-1:0]       r_mplier;
    logic [2*WIDTH-1:0]     r_acc;
    logic [CW-1:0]          r_cnt;
    logic                   r_busy;
    logic                   r_done;
    logic [2*WIDTH-1:0]     r_product;

    logic                   w_accept;
    logic                   w_finish;
    logic [WIDTH-1:0]       w_addend;
    logic [WIDTH:0]         w_sum;
    logic [2*WIDTH:0]       w_wide;
    logic [2*WIDTH-1:0]     w_next_acc;
    logic [2*WIDTH-1:0]     w_result;
    logic [WIDTH-1:0]       w_a_in;
    logic [WIDTH-1:0]       w_b_in;

    // Explicit ripple-carry adder; bit WIDTH of the result is the carry-out.
    function automatic logic [WIDTH:0] ripple_add(input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y);
        logic           c;
        logic [WIDTH:0] s;
        c = 1'b0;
        s = {(WIDTH+1){1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        s[WIDTH] = c;
        return s;
    endfunction

`ifdef SEQ_MULT_SIGNED_EN
    logic r_neg;

    // Magnitude of a two's-complement value; the most negative value maps to 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? (~x + {{(WIDTH-1){1'b0}}, 1'b1}) : x;
    endfunction

    // Operand conditioning and final sign correction for signed mode.
    always_comb begin
        w_a_in = a;
        w_b_in = b;
        if (sgn) begin
            w_a_in = magnitude(a);
            w_b_in = magnitude(b);
        end else begin
            w_a_in = a;
            w_b_in = b;
        end
        if (r_neg) begin
            w_result = ~w_next_acc + {{(2*WIDTH-1){1'b0}}, 1'b1};
        end else begin
            w_result = w_next_acc;
        end
    end
`else
    // Unsigned build: operands and result pass straight through.
    always_comb begin
        w_a_in   = a;
        w_b_in   = b;
        w_result = w_next_acc;
    end
`endif

    // One shift-and-add step on the current accumulator.
    always_comb begin
        w_accept = start && (r_state != S_RUN);
        w_finish = (r_state == S_RUN) && (r_cnt == CW'(1));
        if (r_mplier[0]) begin
            w_addend = r_mcand;
        end else begin
            w_addend = {WIDTH{1'b0}};
        end
        w_sum      = ripple_add(r_acc[2*WIDTH-1:WIDTH], w_addend);
        w_wide     = {w_sum, r_acc[WIDTH-1:0]};
        w_next_acc = (2*WIDTH)'(w_wide >> 1);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; a start in RUN is ignored.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next_state = S_RUN;
                else          w_next_state = S_IDLE;
            end
            S_RUN: begin
                if (w_finish) w_next_state = S_DONE;
                else          w_next_state = S_RUN;
            end
            S_DONE: begin
                if (w_accept) w_next_state = S_RUN;
                else          w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, and result/flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand   <= {WIDTH{1'b0}};
            r_mplier  <= {WIDTH{1'b0}};
            r_acc     <= {(2*WIDTH){1'b0}};
            r_cnt     <= {CW{1'b0}};
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_product <= {(2*WIDTH){1'b0}};
`ifdef SEQ_MULT_SIGNED_EN
            r_neg     <= 1'b0;
`endif
        end else begin
            r_busy <= (w_next_state == S_RUN);
            r_done <= (w_next_state == S_DONE);
            if (w_accept) begin
                r_mcand  <= w_a_in;
                r_mplier <= w_b_in;
                r_acc    <= {(2*WIDTH){1'b0}};
                r_cnt    <= CW'(WIDTH);
`ifdef SEQ_MULT_SIGNED_EN
                r_neg    <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
`endif
            end else if (r_state == S_RUN) begin
                r_acc    <= w_next_acc;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt - CW'(1);
                if (w_finish) begin
                    r_product <= w_result;
                end else begin
                    r_product <= r_product;
                end
            end else begin
                r_acc <= r_acc;
            end
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_product;

endmodule
